lcd_hd44780_writer: RTL and testbench
=====================================

Name: lcd_hd44780_writer

Overview:
- Host-side driver for the character LCD (HD44780-compatible, 8-bit bus, write-only).
- Follows the LCD reset-delay block: its oRESET rising edge starts the power-on init sequence.
- After init, accepts single-byte command or data writes from the urna UI logic over a ready/valid handshake.
- Generates LCD_EN pulse timing and post-write settle delays.

Parameters:
EN_CYCLES, 16, iCLK cycles LCD_EN is held high per write (≥ 320 ns at 50 MHz)
SETUP_CYCLES, 2, cycles RS/DATA are stable before LCD_EN rises
SETTLE_CYCLES, 2000, wait after a normal write before the next write (40 µs at 50 MHz)
CLEAR_CYCLES, 100000, wait after clear (0x01) or home (0x02/0x03) commands (2 ms)

Ports:
iCLK  in  1  system clock, 50 MHz
FORCE_RESET  in  1  asynchronous reset, active-low
iSTART  in  1  level; init sequence begins on first cycle iSTART=1 after reset (wired to reset-delay oRESET)
i_valid  in  1  host write request
i_rs  in  1  0 = command, 1 = character data
i_data  in  8  byte to write
o_ready  out  1  block idle and init complete; a write is accepted when i_valid & o_ready
o_init_done  out  1  sticky, high once the init sequence has finished
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  LCD register select
LCD_RW  out  1  tied 0 (write only)
LCD_EN  out  1  LCD enable strobe

Behaviour:
- Reset: FORCE_RESET asynchronous, active-low; clock iCLK. While reset is active and on release: o_ready=0, o_init_done=0, LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, state WAIT_START, all counters 0.
- FSM states: WAIT_START, LOAD, SETUP, EN_HIGH, EN_LOW, SETTLE, READY.
- WAIT_START: stays until iSTART=1, then loads init index 0 and goes to LOAD.
- Init ROM, in order, all with RS=0: 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry mode increment).
- LOAD: drives LCD_RS and LCD_DATA from the current byte (init ROM or latched host byte); goes to SETUP.
- SETUP: holds SETUP_CYCLES cycles, LCD_EN=0.
- EN_HIGH: LCD_EN=1 for exactly EN_CYCLES cycles.
- EN_LOW: one cycle with LCD_EN=0; DATA and RS still held.
- SETTLE: waits CLEAR_CYCLES if the byte was a command (RS=0) with value 0x01, 0x02 or 0x03; otherwise waits SETTLE_CYCLES. LCD_DATA/RS hold their last value.
- After SETTLE during init:
  - If init index < 3: increment index, return to LOAD.
  - Otherwise: set o_init_done, go to READY.
- After SETTLE for a host write: return to READY.
- READY: o_ready=1 (registered from state).
  - On i_valid=1, latch i_rs and i_data that cycle; o_ready=0 from the next cycle; go to LOAD.
  - One accepted byte produces exactly one LCD_EN pulse.
- i_valid while o_ready=0 is ignored. No queueing; the host must hold i_valid until accepted.
- Accept-to-EN-rise latency: 1 (LOAD) + SETUP_CYCLES cycles.
- Delay counter: 17-bit, counts 0..N-1, saturates; it never wraps inside a state.
- iSTART dropping after init has begun has no effect.
- Reset mid-operation: FORCE_RESET low at any state aborts immediately. LCD_EN must drop asynchronously (never left high), and the full init sequence reruns on the next iSTART.
- Simultaneous reset release and iSTART=1: init starts on the first clock edge after release.

Decomposition:
- Package lcd_hd44780_pkg:
  - state enum.
  - init ROM constant (4 × 8-bit) and INIT_LEN=4.
  - command constants CMD_CLEAR=0x01, CMD_HOME=0x02.
  - function is_long_cmd(rs, byte).
- Sub-module lcd_bus_cycle: owns SETUP/EN_HIGH/EN_LOW/SETTLE timing for one byte.
  - Inputs: start, rs, data, long_wait. Output: done pulse.
  - The top FSM handles only sequencing, init indexing and the handshake.

Test Plan:
1. Reset, then iSTART=1 → exactly four LCD_EN pulses with RS=0, DATA 0x38, 0x0C, 0x01, 0x06 in order. Gap after 0x01 ≥ CLEAR_CYCLES, other gaps ≥ SETTLE_CYCLES. Then o_init_done=1 and o_ready=1.
2. After init, i_valid=1, i_rs=1, i_data=0x41 for one cycle → o_ready falls next cycle. LCD_EN rises 1+SETUP_CYCLES cycles after accept and stays high EN_CYCLES cycles with RS=1, DATA=0x41. o_ready returns after SETTLE_CYCLES.
3. Command write i_rs=0, i_data=0x01 → post-pulse wait equals CLEAR_CYCLES. Command 0x80 → wait equals SETTLE_CYCLES.
4. i_valid held high while busy with a changing i_data → only the byte present at the accept cycle is written; no extra EN pulses.
5. FORCE_RESET pulsed low during EN_HIGH of the second init byte → LCD_EN=0 immediately, o_init_done=0. With iSTART=1 after release, the full four-command init repeats from 0x38.
6. iSTART held 0 for 1000 cycles after reset → no LCD_EN activity and o_ready=0 throughout.

Source files
------------

// File: rtl/lcd_hd44780_pkg.sv
// Shared types and constants for the HD44780 character-LCD write driver.
// Holds the power-on init ROM and the long-command decode.
package lcd_hd44780_pkg;

  localparam int CNT_W    = 17;
  localparam int INIT_LEN = 4;
  localparam int IDX_W    = 2;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Element 0 is sent first: function set, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  // Top-level sequencing; BUS_CYCLE covers the whole strobe/settle of one byte.
  typedef enum logic [1:0] {WAIT_START, LOAD, BUS_CYCLE, READY} state_t;

  // Per-byte bus timing phases.
  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, EN_LOW, SETTLE} phase_t;

  // Clear and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == (CMD_HOME | 8'h01)));
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// Drives one LCD write: RS/DATA setup, EN strobe, EN low, then execution wait.
// Pulses done on the last settle cycle so the sequencer can reload without a gap.
module lcd_bus_cycle
  import lcd_hd44780_pkg::*;
#(
  parameter int unsigned EN_CYCLES     = 16,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2000,
  parameter int unsigned CLEAR_CYCLES  = 100000
) (
  input  logic       iCLK,
  input  logic       FORCE_RESET,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       lcd_en
);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST     = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);

  phase_t           phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             en_reg, en_next;
  logic             rs_reg, long_reg;
  logic [7:0]       data_reg;
  logic [CNT_W-1:0] settle_last;

  assign settle_last = long_reg ? CLEAR_LAST : SETTLE_LAST;

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
    en_next    = en_reg;
    done       = 1'b0;
    case (phase_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) phase_next = SETUP;
      end
      SETUP: if (cnt_reg == SETUP_LAST) begin
        phase_next = EN_HIGH;
        cnt_next   = '0;
        en_next    = 1'b1;
      end
      EN_HIGH: if (cnt_reg == EN_LAST) begin
        phase_next = EN_LOW;
        cnt_next   = '0;
        en_next    = 1'b0;
      end
      EN_LOW: begin
        phase_next = SETTLE;
        cnt_next   = '0;
      end
      SETTLE: if (cnt_reg == settle_last) begin
        phase_next = IDLE;
        cnt_next   = '0;
        done       = 1'b1;
      end
      default: begin
        phase_next = IDLE;
        cnt_next   = '0;
        en_next    = 1'b0;
      end
    endcase
  end

  // Async clear keeps the strobe from ever being left high across a reset.
  always_ff @(posedge iCLK or negedge FORCE_RESET) begin
    if (!FORCE_RESET) begin
      phase_reg <= IDLE;
      cnt_reg   <= '0;
      en_reg    <= 1'b0;
      rs_reg    <= 1'b0;
      long_reg  <= 1'b0;
      data_reg  <= 8'h00;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      en_reg    <= en_next;
      if (phase_reg == IDLE && start) begin
        rs_reg   <= rs;
        data_reg <= data;
        long_reg <= long_wait;
      end
    end
  end

  assign lcd_rs   = rs_reg;
  assign lcd_data = data_reg;
  assign lcd_en   = en_reg;

endmodule

// File: rtl/lcd_hd44780_writer.sv
// HD44780 8-bit write-only driver: runs the power-on init sequence on iSTART,
// then forwards single host bytes over a ready/valid handshake.
module lcd_hd44780_writer
  import lcd_hd44780_pkg::*;
#(
  parameter int unsigned EN_CYCLES     = 16,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2000,
  parameter int unsigned CLEAR_CYCLES  = 100000
) (
  input  logic       iCLK,
  input  logic       FORCE_RESET,
  input  logic       iSTART,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             init_done_reg, init_done_next;
  logic             ready_reg;
  logic             host_rs_reg;
  logic [7:0]       host_data_reg;
  logic             cur_rs;
  logic [7:0]       cur_data;
  logic             bus_done;

  assign cur_rs   = init_done_reg ? host_rs_reg : 1'b0;
  assign cur_data = init_done_reg ? host_data_reg : INIT_ROM[idx_reg];

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    init_done_next = init_done_reg;
    case (state_reg)
      WAIT_START: if (iSTART) begin
        idx_next   = '0;
        state_next = LOAD;
      end
      LOAD: state_next = BUS_CYCLE;
      BUS_CYCLE: if (bus_done) begin
        if (init_done_reg) begin
          state_next = READY;
        end else if (idx_reg == IDX_W'(INIT_LEN - 1)) begin
          init_done_next = 1'b1;
          state_next     = READY;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = LOAD;
        end
      end
      READY: if (i_valid) state_next = LOAD;
      default: state_next = WAIT_START;
    endcase
  end

  // o_ready is registered from the next state so it drops the cycle after accept.
  always_ff @(posedge iCLK or negedge FORCE_RESET) begin
    if (!FORCE_RESET) begin
      state_reg     <= WAIT_START;
      idx_reg       <= '0;
      init_done_reg <= 1'b0;
      ready_reg     <= 1'b0;
      host_rs_reg   <= 1'b0;
      host_data_reg <= 8'h00;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      init_done_reg <= init_done_next;
      ready_reg     <= (state_next == READY);
      if (state_reg == READY && i_valid) begin
        host_rs_reg   <= i_rs;
        host_data_reg <= i_data;
      end
    end
  end

  lcd_bus_cycle #(
    .EN_CYCLES    (EN_CYCLES),
    .SETUP_CYCLES (SETUP_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CLEAR_CYCLES (CLEAR_CYCLES)
  ) u_bus (
    .iCLK       (iCLK),
    .FORCE_RESET(FORCE_RESET),
    .start      (state_reg == LOAD),
    .rs         (cur_rs),
    .data       (cur_data),
    .long_wait  (is_long_cmd(cur_rs, cur_data)),
    .done       (bus_done),
    .lcd_rs     (LCD_RS),
    .lcd_data   (LCD_DATA),
    .lcd_en     (LCD_EN)
  );

  assign o_ready     = ready_reg;
  assign o_init_done = init_done_reg;
  assign LCD_RW      = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Directed bench for lcd_hd44780_writer with shortened timing parameters.
// A negedge monitor logs every LCD_EN pulse; the main block checks them.
module tb_lcd_hd44780_writer;

  localparam int EN_C = 4;
  localparam int SU_C = 2;
  localparam int ST_C = 20;
  localparam int CL_C = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_hd44780_writer #(
    .EN_CYCLES    (EN_C),
    .SETUP_CYCLES (SU_C),
    .SETTLE_CYCLES(ST_C),
    .CLEAR_CYCLES (CL_C)
  ) dut (
    .iCLK       (clk),
    .FORCE_RESET(rst_n),
    .iSTART     (start),
    .i_valid    (valid),
    .i_rs       (rs),
    .i_data     (data),
    .o_ready    (ready),
    .o_init_done(init_done),
    .LCD_DATA   (lcd_data),
    .LCD_RS     (lcd_rs),
    .LCD_RW     (lcd_rw),
    .LCD_EN     (lcd_en)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log sampled mid-cycle.
  int         rise_q[$];
  int         fall_q[$];
  logic [7:0] data_q[$];
  logic       rs_q[$];
  int         unstable = 0;
  int         ready_rise = -1;
  int         ready_hi_cnt = 0;
  logic       en_prev = 1'b0;
  logic       ready_prev = 1'b0;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      rise_q.push_back(cyc);
      data_q.push_back(lcd_data);
      rs_q.push_back(lcd_rs);
    end else if (lcd_en && data_q.size() > 0 && (lcd_data !== data_q[$] || lcd_rs !== rs_q[$])) begin
      unstable <= unstable + 1;
    end
    if (!lcd_en && en_prev) fall_q.push_back(cyc);
    if (ready && !ready_prev) ready_rise <= cyc;
    if (ready) ready_hi_cnt <= ready_hi_cnt + 1;
    en_prev    <= lcd_en;
    ready_prev <= ready;
  end

  int n_asserts = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rise_q.delete();
    fall_q.delete();
    data_q.delete();
    rs_q.delete();
  endtask

  task automatic wait_init(input string tag);
    int k = 0;
    while (!init_done && k < 1000) begin
      tick(1);
      k++;
    end
    check($sformatf("%s_init_timeout", tag), init_done, 1);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready && k < 1000) begin
      tick(1);
      k++;
    end
    check($sformatf("%s_ready_timeout", tag), ready, 1);
  endtask

  task automatic do_write(input string tag, input logic r, input logic [7:0] d, output int acc);
    wait_ready(tag);
    valid = 1'b1;
    rs    = r;
    data  = d;
    tick(1);
    acc   = cyc;
    valid = 1'b0;
    check($sformatf("%s_ready_drop", tag), ready, 0);
  endtask

  // One pulse per byte; EN rises 1+SETUP after accept; ready returns settle+1 after EN falls.
  task automatic check_write(input string tag, input int np, input int acc,
                             input logic exp_rs, input logic [7:0] exp_d, input int exp_wait);
    wait_ready(tag);
    tick(1);
    check($sformatf("%s_pulses", tag), rise_q.size(), np + 1);
    if (rise_q.size() == np + 1 && fall_q.size() == np + 1) begin
      check($sformatf("%s_latency", tag), rise_q[np] - acc, 1 + SU_C);
      check($sformatf("%s_width", tag), fall_q[np] - rise_q[np], EN_C);
      check($sformatf("%s_rs", tag), rs_q[np], exp_rs);
      check($sformatf("%s_data", tag), data_q[np], exp_d);
      check($sformatf("%s_wait", tag), ready_rise - fall_q[np], exp_wait);
    end
  endtask

  task automatic check_init(input string tag, input int s0);
    logic [7:0] rom [4];
    int         gap [3];
    rom = '{8'h38, 8'h0C, 8'h01, 8'h06};
    // low samples between pulses: EN_LOW + settle + LOAD + SETUP
    gap = '{ST_C + 2 + SU_C, ST_C + 2 + SU_C, CL_C + 2 + SU_C};
    check($sformatf("%s_pulses", tag), rise_q.size(), 4);
    if (rise_q.size() == 4 && fall_q.size() == 4) begin
      check($sformatf("%s_first_rise", tag), rise_q[0] - s0, 2 + SU_C);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_data%0d", tag, i), data_q[i], rom[i]);
        check($sformatf("%s_rs%0d", tag, i), rs_q[i], 0);
        check($sformatf("%s_width%0d", tag, i), fall_q[i] - rise_q[i], EN_C);
      end
      for (int i = 0; i < 3; i++)
        check($sformatf("%s_gap%0d", tag, i), rise_q[i + 1] - fall_q[i], gap[i]);
    end
    check($sformatf("%s_ready", tag), ready, 1);
  endtask

  initial begin
    int acc, np, s0, k;

    // Reset values
    tick(3);
    check("rst_ready", ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 8'h00);

    // No activity without iSTART
    rst_n = 1'b1;
    tick(1000);
    check("idle_pulses", rise_q.size(), 0);
    check("idle_ready", ready_hi_cnt, 0);
    check("idle_init_done", init_done, 0);

    // Power-on init
    start = 1'b1;
    s0 = cyc;
    wait_init("init");
    tick(1);
    check_init("init", s0);
    start = 1'b0;

    // Host writes
    np = rise_q.size();
    do_write("wr41", 1'b1, 8'h41, acc);
    check_write("wr41", np, acc, 1'b1, 8'h41, ST_C + 1);
    np = rise_q.size();
    do_write("clr", 1'b0, 8'h01, acc);
    check_write("clr", np, acc, 1'b0, 8'h01, CL_C + 1);
    np = rise_q.size();
    do_write("home3", 1'b0, 8'h03, acc);
    check_write("home3", np, acc, 1'b0, 8'h03, CL_C + 1);
    np = rise_q.size();
    do_write("cmd80", 1'b0, 8'h80, acc);
    check_write("cmd80", np, acc, 1'b0, 8'h80, ST_C + 1);
    np = rise_q.size();
    do_write("data01", 1'b1, 8'h01, acc);
    check_write("data01", np, acc, 1'b1, 8'h01, ST_C + 1);

    // i_valid held through busy with changing data
    wait_ready("hold");
    np = rise_q.size();
    valid = 1'b1;
    rs = 1'b1;
    data = 8'h50;
    tick(1);
    acc = cyc;
    for (int i = 0; i < 20; i++) begin
      data = 8'h51 + 8'(i);
      tick(1);
    end
    check("hold_ready_low", ready, 0);
    valid = 1'b0;
    check_write("hold", np, acc, 1'b1, 8'h50, ST_C + 1);

    // Reset during the second init strobe, released together with iSTART
    rst_n = 1'b0;
    tick(2);
    clear_log();
    rst_n = 1'b1;
    start = 1'b1;
    s0 = cyc;
    k = 0;
    while (!(lcd_en === 1'b1 && lcd_data === 8'h0C) && k < 500) begin
      tick(1);
      k++;
    end
    check("mid_reach_second", lcd_data, 8'h0C);
    check("mid_pulses_before", rise_q.size(), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_en_drop", lcd_en, 0);
    check("mid_init_done", init_done, 0);
    check("mid_ready", ready, 0);
    check("mid_data", lcd_data, 8'h00);
    tick(2);
    clear_log();
    rst_n = 1'b1;
    s0 = cyc;
    wait_init("rerun");
    tick(1);
    check_init("rerun", s0);

    check("en_hold_stable", unstable, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
